// File: rtl/rvlab_rstmgr.sv
`default_nettype none
// ============================================================================
//  Module   : rvlab_rstmgr
//  Purpose  : System reset manager. Synchronizes MMCM lock and pushbutton,
//             debounces the button, sequences a glitch-free registered
//             system reset with a programmable hold time, and keeps sticky
//             reset-cause flags plus a saturating reset-event counter.
//  Revision : 1.0  initial release
// ============================================================================
module rvlab_rstmgr #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int HOLD_CYCLES     = 16
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       locked_i,
   input  logic       btn_i,
   input  logic       sw_rst_req_i,
   input  logic       cause_clr_i,
   output logic       sys_rst_o,
   output logic       sys_rst_no,
   output logic [2:0] rst_cause_o,
   output logic [7:0] rst_count_o
);

   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   localparam logic [1:0] ST_ASSERT = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;

   logic [SYNC_STAGES-1:0] lk_sync_q, lk_sync_d;
   logic [SYNC_STAGES-1:0] bt_sync_q, bt_sync_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   btn_db_q, btn_db_d;
   logic [1:0]             state_q, state_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic                   sys_rst_q, sys_rst_d;
   logic                   sys_rst_n_q, sys_rst_n_d;
   logic [2:0]             cause_q, cause_d;
   logic [7:0]             count_q, count_d;

   logic lk_s;
   logic bt_s;
   logic src;

   assign lk_s = lk_sync_q[SYNC_STAGES-1];
   assign bt_s = bt_sync_q[SYNC_STAGES-1];
   assign src  = !lk_s | btn_db_q | sw_rst_req_i;

   // Synchronizer shift and button debounce: the debounced level only follows
   // the synchronized button after DEBOUNCE_CYCLES consecutive differing cycles.
   always_comb begin
      lk_sync_d = {lk_sync_q[SYNC_STAGES-2:0], locked_i};
      bt_sync_d = {bt_sync_q[SYNC_STAGES-2:0], btn_i};
      db_cnt_d  = '0;
      btn_db_d  = btn_db_q;
      if (bt_s != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = bt_s;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   // Reset sequencing FSM; the reset outputs are derived from the next state
   // so they are registered without an extra cycle of latency.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      count_d = count_q;
      case (state_q)
         ST_ASSERT: begin
            if (!src) begin
               state_d = ST_HOLD;
               hold_d  = '0;
            end
         end
         ST_HOLD: begin
            hold_d = hold_q + 1'b1;
            if (src) begin
               state_d = ST_ASSERT;
            end else if (hold_q == HOLD_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (src) begin
               state_d = ST_ASSERT;
               if (count_q != 8'hFF) begin
                  count_d = count_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_ASSERT;
         end
      endcase
      sys_rst_d   = (state_d != ST_RUN);
      sys_rst_n_d = (state_d == ST_RUN);
   end

   // Sticky cause flags: clear first, then any active source sets its bit.
   always_comb begin
      cause_d = cause_clr_i ? 3'b000 : cause_q;
      cause_d = cause_d | {sw_rst_req_i, btn_db_q, !lk_s};
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lk_sync_q   <= '0;
         bt_sync_q   <= '0;
         db_cnt_q    <= '0;
         btn_db_q    <= 1'b0;
         state_q     <= ST_ASSERT;
         hold_q      <= '0;
         sys_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         cause_q     <= 3'b000;
         count_q     <= 8'd0;
      end else begin
         lk_sync_q   <= lk_sync_d;
         bt_sync_q   <= bt_sync_d;
         db_cnt_q    <= db_cnt_d;
         btn_db_q    <= btn_db_d;
         state_q     <= state_d;
         hold_q      <= hold_d;
         sys_rst_q   <= sys_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         cause_q     <= cause_d;
         count_q     <= count_d;
      end
   end

   assign sys_rst_o   = sys_rst_q;
   assign sys_rst_no  = sys_rst_n_q;
   assign rst_cause_o = cause_q;
   assign rst_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rvlab_rstmgr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rvlab_rstmgr
//  Purpose  : Directed self-checking bench for rvlab_rstmgr. Expected
//             sys_rst_o waveforms are queued when stimulus is applied and
//             compared cycle by cycle by a monitor on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rvlab_rstmgr;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       locked_i;
   logic       btn_i;
   logic       sw_rst_req_i;
   logic       cause_clr_i;
   logic       sys_rst_o;
   logic       sys_rst_no;
   logic [2:0] rst_cause_o;
   logic [7:0] rst_count_o;

   int errors = 0;
   int checks = 0;
   int exp_cnt;
   logic mon_en = 1'b0;
   logic exp_q[$];

   rvlab_rstmgr #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_CYCLES(8),
      .HOLD_CYCLES    (16)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .locked_i    (locked_i),
      .btn_i       (btn_i),
      .sw_rst_req_i(sw_rst_req_i),
      .cause_clr_i (cause_clr_i),
      .sys_rst_o   (sys_rst_o),
      .sys_rst_no  (sys_rst_no),
      .rst_cause_o (rst_cause_o),
      .rst_count_o (rst_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         step();
         n++;
      end
      chk("drain_timeout", 8'(exp_q.size()), 8'd0);
   endtask

   task automatic wait_low(input string tag, input int bound);
      int n = 0;
      while (sys_rst_o !== 1'b0 && n < bound) begin
         step();
         n++;
      end
      chk(tag, {7'd0, sys_rst_o}, 8'd0);
   endtask

   task automatic clear_causes();
      cause_clr_i = 1'b1;
      step();
      cause_clr_i = 1'b0;
      chk("cause_cleared", {5'd0, rst_cause_o}, 8'd0);
   endtask

   // Falling-edge monitor: pops one expected reset level per cycle.
   always @(negedge clk_i) begin
      if (mon_en) begin
         chk("rst_n_inverse", {7'd0, sys_rst_no}, {7'd0, ~sys_rst_o});
         if (exp_q.size() != 0) begin
            logic e;
            e = exp_q.pop_front();
            chk("sys_rst_wave", {7'd0, sys_rst_o}, {7'd0, e});
         end
      end
   end

   initial begin
      rst_i = 1'b1; locked_i = 1'b1; btn_i = 1'b0;
      sw_rst_req_i = 1'b0; cause_clr_i = 1'b0;

      // Reset state
      step();
      mon_en = 1'b1;
      chk("reset_sys_rst", {7'd0, sys_rst_o}, 8'd1);
      chk("reset_sys_rst_n", {7'd0, sys_rst_no}, 8'd0);
      chk("reset_cause", {5'd0, rst_cause_o}, 8'd0);
      chk("reset_count", rst_count_o, 8'd0);
      step();
      step();

      // Release: low 2+1+16 cycles after release
      rst_i = 1'b0;
      push(1'b1, 19);
      push(1'b0, 3);
      drain();
      chk("startup_count", rst_count_o, 8'd0);
      clear_causes();

      // Software pulse in RUN: 17 cycles of reset
      sw_rst_req_i = 1'b1;
      push(1'b0, 1); push(1'b1, 17); push(1'b0, 3);
      step();
      sw_rst_req_i = 1'b0;
      chk("sw_cause", {5'd0, rst_cause_o}, 8'h4);
      chk("sw_count", rst_count_o, 8'd1);
      drain();

      // Lock loss for 40 cycles
      clear_causes();
      locked_i = 1'b0;
      push(1'b0, 3); push(1'b1, 56); push(1'b0, 3);
      repeat (40) step();
      locked_i = 1'b1;
      drain();
      chk("lock_cause", {5'd0, rst_cause_o}, 8'h1);
      chk("lock_count", rst_count_o, 8'd2);

      // Button bounce shorter than debounce window: no reset
      clear_causes();
      push(1'b0, 33);
      for (int w = 1; w <= 5; w++) begin
         btn_i = 1'b1;
         repeat (w) step();
         btn_i = 1'b0;
         repeat (3) step();
      end
      drain();
      chk("bounce_cause", {5'd0, rst_cause_o}, 8'd0);
      chk("bounce_count", rst_count_o, 8'd2);

      // Button held 20 cycles
      btn_i = 1'b1;
      push(1'b0, 11); push(1'b1, 36); push(1'b0, 3);
      repeat (20) step();
      btn_i = 1'b0;
      drain();
      chk("btn_cause", {5'd0, rst_cause_o}, 8'h2);
      chk("btn_count", rst_count_o, 8'd3);

      // Source re-asserted at hold counter 10 restarts the hold
      sw_rst_req_i = 1'b1;
      push(1'b0, 1); push(1'b1, 29); push(1'b0, 3);
      step();
      sw_rst_req_i = 1'b0;
      repeat (11) step();
      sw_rst_req_i = 1'b1;
      step();
      sw_rst_req_i = 1'b0;
      drain();
      chk("restart_count", rst_count_o, 8'd4);

      // Saturation of the event counter
      exp_cnt = 4;
      for (int i = 0; i < 300; i++) begin
         sw_rst_req_i = 1'b1;
         step();
         sw_rst_req_i = 1'b0;
         if (exp_cnt < 255) exp_cnt++;
         chk("sat_count", rst_count_o, 8'(exp_cnt));
         wait_low("sat_release", 40);
      end
      chk("sat_final", rst_count_o, 8'd255);

      // Clear together with a software request: set wins
      cause_clr_i = 1'b1;
      sw_rst_req_i = 1'b1;
      step();
      cause_clr_i = 1'b0;
      sw_rst_req_i = 1'b0;
      chk("clr_vs_set", {5'd0, rst_cause_o}, 8'h4);
      chk("sat_hold", rst_count_o, 8'd255);
      wait_low("clr_release", 40);

      // rst_i in the middle of a hold sequence
      sw_rst_req_i = 1'b1;
      step();
      sw_rst_req_i = 1'b0;
      repeat (5) step();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      chk("midrst_sys_rst", {7'd0, sys_rst_o}, 8'd1);
      chk("midrst_count", rst_count_o, 8'd0);
      chk("midrst_cause", {5'd0, rst_cause_o}, 8'd0);
      wait_low("midrst_release", 60);
      chk("midrst_count_after", rst_count_o, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
